fetch_queue_unit: RTL

- Parametrised instruction-fetch front end for the pipelined generation of the MIPS core.
- Replaces the single-cycle PC register and instruction request logic.
- Owns the fetch PC and issues one-at-a-time requests on the datapath instruction port (imemREN/imemaddr/ihit/imemload).
- Buffers returned instructions with their PC and PC+4 in a DEPTH-entry FIFO that the decode stage drains via valid/ready; branch/jump redirects flush the FIFO.

---
 rtl/fetch_queue_unit.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues one request at a time and buffers
// {instr, pc, pc+4} in a DEPTH-entry FIFO for decode. Optional counters behind FETCH_PERF_EN.
module fetch_queue_unit #(
  parameter int                WORD_W  = 32,
  parameter int                DEPTH   = 4,
  parameter logic [WORD_W-1:0] PC_INIT = {WORD_W{1'b0}}
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       ihit,
  input  logic [WORD_W-1:0]          imemload,
  output logic                       imemREN,
  output logic [WORD_W-1:0]          imemaddr,
  input  logic                       redirect,
  input  logic [WORD_W-1:0]          redirect_pc,
  input  logic                       halt,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WORD_W-1:0]          out_instr,
  output logic [WORD_W-1:0]          out_pc,
  output logic [WORD_W-1:0]          out_npc,
  output logic [$clog2(DEPTH):0]     count
`ifdef FETCH_PERF_EN
  ,
  output logic [WORD_W-1:0]          perf_fetched,
  output logic [WORD_W-1:0]          perf_flushed
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FULL   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WORD_W-1:0] r_pc;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW-1:0]     r_wr_ptr;
  logic [CW-1:0]     r_count;
  logic [WORD_W-1:0] r_instr_q [DEPTH];
  logic [WORD_W-1:0] r_pc_q    [DEPTH];
  logic [WORD_W-1:0] r_npc_q   [DEPTH];

  logic              w_push;
  logic              w_pop;
  logic [WORD_W-1:0] w_pc_plus4;

  // Request strobe decodes registered state only, so a same-cycle pop never re-enables it
  assign imemREN    = (r_state == RUN);
  assign imemaddr   = r_pc;
  assign w_pc_plus4 = r_pc + WORD_W'(4);
  assign w_push     = ihit & imemREN & ~redirect;
  assign out_valid  = (r_count != {CW{1'b0}});
  assign w_pop      = out_valid & out_ready & ~redirect;
  assign count      = r_count;
  assign out_instr  = r_instr_q[r_rd_ptr];
  assign out_pc     = r_pc_q[r_rd_ptr];
  assign out_npc    = r_npc_q[r_rd_ptr];

  // Next-state: redirect dominates, HALTED is terminal, FULL tracks count == DEPTH
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN: begin
        if (redirect) begin
          w_state_nxt = halt ? HALTED : RUN;
        end else if (halt) begin
          w_state_nxt = HALTED;
        end else if (w_push && !w_pop && (r_count == CW'(DEPTH - 1))) begin
          w_state_nxt = FULL;
        end else begin
          w_state_nxt = RUN;
        end
      end
      FULL: begin
        if (redirect) begin
          w_state_nxt = halt ? HALTED : RUN;
        end else if (halt) begin
          w_state_nxt = HALTED;
        end else if (w_pop) begin
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = FULL;
        end
      end
      HALTED: begin
        w_state_nxt = HALTED;
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  // State, fetch PC, pointers and occupancy
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= RUN;
      r_pc     <= PC_INIT;
      r_rd_ptr <= {AW{1'b0}};
      r_wr_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      if (redirect) begin
        r_pc     <= redirect_pc;
        r_rd_ptr <= r_wr_ptr;
        r_count  <= {CW{1'b0}};
      end else begin
        if (w_push) begin
          r_pc     <= w_pc_plus4;
          r_wr_ptr <= r_wr_ptr + AW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // FIFO storage, cleared on reset so the head reads zero before the first push
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_instr_q[i] <= {WORD_W{1'b0}};
        r_pc_q[i]    <= {WORD_W{1'b0}};
        r_npc_q[i]   <= {WORD_W{1'b0}};
      end
    end else if (w_push) begin
      r_instr_q[r_wr_ptr] <= imemload;
      r_pc_q[r_wr_ptr]    <= r_pc;
      r_npc_q[r_wr_ptr]   <= w_pc_plus4;
    end
  end

`ifdef FETCH_PERF_EN
  logic [WORD_W-1:0] r_perf_fetched;
  logic [WORD_W-1:0] r_perf_flushed;
  logic [WORD_W:0]   w_flush_sum;
  logic              w_drop;

  // A discarded ihit counts as one more lost entry on top of the flushed occupancy
  assign w_drop       = ihit & imemREN & redirect;
  assign w_flush_sum  = {1'b0, r_perf_flushed} + (WORD_W + 1)'(r_count) + (WORD_W + 1)'(w_drop);
  assign perf_fetched = r_perf_fetched;
  assign perf_flushed = r_perf_flushed;

  // Saturating performance counters
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_perf_fetched <= {WORD_W{1'b0}};
      r_perf_flushed <= {WORD_W{1'b0}};
    end else begin
      if (w_push && (r_perf_fetched != {WORD_W{1'b1}})) begin
        r_perf_fetched <= r_perf_fetched + WORD_W'(1);
      end
      if (redirect) begin
        r_perf_flushed <= w_flush_sum[WORD_W] ? {WORD_W{1'b1}} : w_flush_sum[WORD_W-1:0];
      end
    end
  end
`endif

endmodule
